// File: rtl/rename_ctrl.sv
// Rename-pointer controller: allocates, tracks and frees RNDEPTH physical copies per arch register.
// Optional RENAME_PERF_EN adds a saturating dispatch-stall counter output (stall_cnt).
module rename_ctrl #(
    parameter int RNDEPTH = 4,
    parameter int RNBIT   = 2
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   dsp_valid,
    input  logic [4:0]             dsp_rd,
    output logic                   dsp_ready,
    output logic [RNBIT-1:0]       dsp_rename,
    input  logic [4:0]             rs1_idx,
    input  logic [4:0]             rs2_idx,
    output logic [RNBIT-1:0]       rs1_rename,
    output logic [RNBIT-1:0]       rs2_rename,
    output logic                   rs1_rdy,
    output logic                   rs2_rdy,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [RNBIT-1:0]       wb_rename,
    input  logic                   cmt_valid,
    input  logic [4:0]             cmt_rd,
    input  logic [RNBIT-1:0]       cmt_rename,
    input  logic                   flush,
    output logic [32*RNBIT-1:0]    arch_rename
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam logic [1:0] ST_FREE      = 2'd0;
    localparam logic [1:0] ST_RENAMED   = 2'd1;
    localparam logic [1:0] ST_WROTEBACK = 2'd2;
    localparam logic [1:0] ST_COMMITTED = 2'd3;

    logic [31:0][RNDEPTH-1:0][1:0] r_state;
    logic [31:0][RNDEPTH-1:0][1:0] w_state_nxt;
    logic [31:0][RNBIT-1:0]        r_spec;
    logic [31:0][RNBIT-1:0]        r_arch;
    logic [31:0][RNBIT-1:0]        w_spec_nxt;
    logic [31:0][RNBIT-1:0]        w_arch_nxt;

    logic             w_found;
    logic [RNBIT-1:0] w_grant;
    logic [RNBIT-1:0] w_cand;
    logic             w_dsp_fire;
    logic             w_wb_ok;
    logic             w_cmt_ok;

    // Pointer arithmetic wraps in RNBIT bits, so RNDEPTH must be a power of two.
    // Walk from farthest to nearest so the nearest free copy after spec_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = RNDEPTH - 1; k >= 1; k--) begin
            w_cand = r_spec[dsp_rd] + RNBIT'(k);
            if (r_state[dsp_rd][w_cand] == ST_FREE) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign dsp_ready  = (dsp_rd == 5'd0) | w_found;
    assign dsp_rename = (dsp_rd == 5'd0) ? '0 : w_grant;
    assign w_dsp_fire = dsp_valid & (dsp_rd != 5'd0) & w_found & ~flush;

    assign rs1_rename = (rs1_idx == 5'd0) ? '0 : r_spec[rs1_idx];
    assign rs2_rename = (rs2_idx == 5'd0) ? '0 : r_spec[rs2_idx];
    assign rs1_rdy    = (rs1_idx == 5'd0) |
                        (r_state[rs1_idx][r_spec[rs1_idx]] == ST_WROTEBACK) |
                        (r_state[rs1_idx][r_spec[rs1_idx]] == ST_COMMITTED);
    assign rs2_rdy    = (rs2_idx == 5'd0) |
                        (r_state[rs2_idx][r_spec[rs2_idx]] == ST_WROTEBACK) |
                        (r_state[rs2_idx][r_spec[rs2_idx]] == ST_COMMITTED);

    assign w_wb_ok  = wb_valid & (wb_rd != 5'd0) & ~flush &
                      (r_state[wb_rd][wb_rename] == ST_RENAMED);
    assign w_cmt_ok = cmt_valid & (cmt_rd != 5'd0) &
                      (r_state[cmt_rd][cmt_rename] == ST_WROTEBACK);

    assign arch_rename = r_arch;

    // Applied in order commit, writeback, dispatch, flush; later steps see earlier results.
    always_comb begin
        w_state_nxt = r_state;
        w_spec_nxt  = r_spec;
        w_arch_nxt  = r_arch;
        if (w_cmt_ok) begin
            w_state_nxt[cmt_rd][r_arch[cmt_rd]] = ST_FREE;
            w_state_nxt[cmt_rd][cmt_rename]     = ST_COMMITTED;
            w_arch_nxt[cmt_rd]                  = cmt_rename;
        end
        if (w_wb_ok) begin
            w_state_nxt[wb_rd][wb_rename] = ST_WROTEBACK;
        end
        if (w_dsp_fire) begin
            w_state_nxt[dsp_rd][w_grant] = ST_RENAMED;
            w_spec_nxt[dsp_rd]           = w_grant;
        end
        if (flush) begin
            for (int r = 1; r < 32; r++) begin
                for (int c = 0; c < RNDEPTH; c++) begin
                    if ((w_state_nxt[r][c] == ST_RENAMED) || (w_state_nxt[r][c] == ST_WROTEBACK)) begin
                        w_state_nxt[r][c] = ST_FREE;
                    end
                end
                w_spec_nxt[r] = w_arch_nxt[r];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < RNDEPTH; c++) begin
                    r_state[r][c] <= (c == 0) ? ST_COMMITTED : ST_FREE;
                end
            end
            r_spec <= '0;
            r_arch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_spec  <= w_spec_nxt;
            r_arch  <= w_arch_nxt;
        end
    end

`ifdef RENAME_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
        end else if (dsp_valid && !dsp_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
// Scoreboard bench for rename_ctrl: stimulus queues expected outputs, a negedge monitor compares.
module tb_rename_ctrl;
    localparam int RNBIT = 2;

    logic             CLK = 1'b0;
    logic             RSTn;
    logic             dsp_valid;
    logic [4:0]       dsp_rd;
    logic             dsp_ready;
    logic [RNBIT-1:0] dsp_rename;
    logic [4:0]       rs1_idx, rs2_idx;
    logic [RNBIT-1:0] rs1_rename, rs2_rename;
    logic             rs1_rdy, rs2_rdy;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [RNBIT-1:0] wb_rename;
    logic             cmt_valid;
    logic [4:0]       cmt_rd;
    logic [RNBIT-1:0] cmt_rename;
    logic             flush;
    logic [32*RNBIT-1:0] arch_rename;
`ifdef RENAME_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    rename_ctrl #(.RNDEPTH(4), .RNBIT(RNBIT)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .dsp_valid(dsp_valid), .dsp_rd(dsp_rd), .dsp_ready(dsp_ready), .dsp_rename(dsp_rename),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_rename(rs1_rename), .rs2_rename(rs2_rename),
        .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rename(wb_rename),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rename(cmt_rename),
        .flush(flush), .arch_rename(arch_rename)
`ifdef RENAME_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    localparam int K_RDY = 0, K_REN = 1, K_RS1 = 2, K_RS1RDY = 3, K_RS2 = 4, K_RS2RDY = 5,
                   K_ARCH = 6, K_STALL = 7;

    typedef struct {
        string name;
        int    kind;
        int    idx;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int get_val(int kind, int idx);
        case (kind)
            K_RDY:    return int'(dsp_ready);
            K_REN:    return int'(dsp_rename);
            K_RS1:    return int'(rs1_rename);
            K_RS1RDY: return int'(rs1_rdy);
            K_RS2:    return int'(rs2_rename);
            K_RS2RDY: return int'(rs2_rdy);
            K_ARCH:   return int'(arch_rename[idx*RNBIT +: RNBIT]);
`ifdef RENAME_PERF_EN
            K_STALL:  return int'(stall_cnt);
`endif
            default:  return -1;
        endcase
    endfunction

    task automatic push_exp(input string n, input int kind, input int idx, input int v);
        sb_q.push_back('{n, kind, idx, v});
    endtask

    always @(negedge CLK) begin
        exp_t e;
        int   got;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = get_val(e.kind, e.idx);
            checks++;
            if (got != e.val) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, got, e.val);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        dsp_valid = 1'b0;
        wb_valid  = 1'b0;
        cmt_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RSTn = 1'b0;
        idle();
        dsp_rd = 5'd5; rs1_idx = 5'd5; rs2_idx = 5'd0;
        wb_rd = '0; wb_rename = '0; cmt_rd = '0; cmt_rename = '0;
        #1;
        push_exp("rst_dsp_ready", K_RDY, 0, 1);
        push_exp("rst_dsp_rename", K_REN, 0, 1);
        push_exp("rst_rs1_rename", K_RS1, 0, 0);
        push_exp("rst_rs1_rdy", K_RS1RDY, 0, 1);
        push_exp("rst_rs2_rdy", K_RS2RDY, 0, 1);
        push_exp("rst_arch5", K_ARCH, 5, 0);
`ifdef RENAME_PERF_EN
        push_exp("rst_stall", K_STALL, 0, 0);
`endif
        cyc();
        RSTn = 1'b1;

        // Test 1: first allocation of x5
        dsp_valid = 1'b1; dsp_rd = 5'd5;
        push_exp("t1_alloc1", K_REN, 0, 1);
        cyc();
        push_exp("t1_rs1_rename", K_RS1, 0, 1);
        push_exp("t1_rs1_rdy", K_RS1RDY, 0, 0);
        // Test 2: fill all copies of x5
        push_exp("t2_alloc2", K_REN, 0, 2);
        cyc();
        push_exp("t2_alloc3", K_REN, 0, 3);
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_rename = 2'd1;
        push_exp("t2_full_ready", K_RDY, 0, 0);
        push_exp("t2_rs1_rename3", K_RS1, 0, 3);
        cyc();
        idle();
        cmt_valid = 1'b1; cmt_rd = 5'd5; cmt_rename = 2'd1;
        push_exp("t2_full_before_cmt", K_RDY, 0, 0);
        cyc();
        idle();
        push_exp("t2_ready_after_cmt", K_RDY, 0, 1);
        push_exp("t2_rename_after_cmt", K_REN, 0, 0);
        push_exp("t2_arch5", K_ARCH, 5, 1);
        cyc();

        // Test 3: writeback ready timing and ignored writebacks on x6
        dsp_valid = 1'b1; dsp_rd = 5'd6;
        push_exp("t3_alloc", K_REN, 0, 1);
        cyc();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd6; wb_rename = 2'd1; rs1_idx = 5'd6;
        push_exp("t3_rs1_rename", K_RS1, 0, 1);
        push_exp("t3_no_bypass", K_RS1RDY, 0, 0);
        cyc();
        push_exp("t3_rdy_after_wb", K_RS1RDY, 0, 1);
        cyc();
        wb_rename = 2'd2;
        push_exp("t3_rdy_after_rewb", K_RS1RDY, 0, 1);
        cyc();
        idle();
        push_exp("t3_rs1_still1", K_RS1, 0, 1);
        push_exp("t3_copy2_still_free", K_REN, 0, 2);
        cyc();

        // Test 4: flush discards x7 speculative copies
        dsp_valid = 1'b1; dsp_rd = 5'd7;
        push_exp("t4_alloc1", K_REN, 0, 1);
        cyc();
        push_exp("t4_alloc2", K_REN, 0, 2);
        cyc();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_rename = 2'd1; rs1_idx = 5'd7;
        push_exp("t4_rs1_rename2", K_RS1, 0, 2);
        push_exp("t4_rs1_rdy0", K_RS1RDY, 0, 0);
        cyc();
        idle();
        flush = 1'b1; dsp_valid = 1'b1;
        push_exp("t4_ready_in_flush", K_RDY, 0, 1);
        push_exp("t4_rename_in_flush", K_REN, 0, 3);
        cyc();
        idle();
        rs2_idx = 5'd5;
        push_exp("t4_rs1_rename0", K_RS1, 0, 0);
        push_exp("t4_rs1_rdy1", K_RS1RDY, 0, 1);
        push_exp("t4_arch7", K_ARCH, 7, 0);
        push_exp("t4_x5_rename", K_RS2, 0, 1);
        push_exp("t4_x5_rdy", K_RS2RDY, 0, 1);
        // Test 5: commit and flush in the same cycle
        dsp_valid = 1'b1;
        push_exp("t5_alloc1", K_REN, 0, 1);
        cyc();
        push_exp("t5_alloc2", K_REN, 0, 2);
        cyc();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_rename = 2'd1;
        cyc();
        idle();
        cmt_valid = 1'b1; cmt_rd = 5'd7; cmt_rename = 2'd1; flush = 1'b1;
        cyc();
        idle();
        dsp_valid = 1'b1;
        push_exp("t5_arch7", K_ARCH, 7, 1);
        push_exp("t5_spec7", K_RS1, 0, 1);
        push_exp("t5_rdy7", K_RS1RDY, 0, 1);
        push_exp("t5_copy2_free", K_REN, 0, 2);
        cyc();
        push_exp("t5_copy3_free", K_REN, 0, 3);
        cyc();
        push_exp("t5_copy0_free", K_REN, 0, 0);
        cyc();
        push_exp("t5_full", K_RDY, 0, 0);
        cyc();

        // Test 6: x0 and stall counting
        idle();
        dsp_valid = 1'b1; dsp_rd = 5'd0; rs1_idx = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_rename = 2'd1;
        cmt_valid = 1'b1; cmt_rd = 5'd0; cmt_rename = 2'd1;
        push_exp("t6_x0_ready", K_RDY, 0, 1);
        push_exp("t6_x0_rename", K_REN, 0, 0);
        push_exp("t6_x0_rs1", K_RS1, 0, 0);
        push_exp("t6_x0_rs1rdy", K_RS1RDY, 0, 1);
        cyc();
        idle();
        push_exp("t6_x0_arch", K_ARCH, 0, 0);
        push_exp("t6_x0_rename_after", K_REN, 0, 0);
        cyc();
        dsp_valid = 1'b1; dsp_rd = 5'd7; rs1_idx = 5'd7;
        push_exp("t6_stall_ready", K_RDY, 0, 0);
        for (int i = 0; i < 10; i++) cyc();
        idle();
`ifdef RENAME_PERF_EN
        push_exp("t6_stall_cnt", K_STALL, 0, 12);
`endif
        push_exp("t6_rs1_rename", K_RS1, 0, 0);
        push_exp("t6_rs1_rdy", K_RS1RDY, 0, 0);
        cyc();

        // Asynchronous reset mid-operation
        RSTn = 1'b0;
        push_exp("rst2_arch5", K_ARCH, 5, 0);
        push_exp("rst2_arch7", K_ARCH, 7, 0);
        push_exp("rst2_rs1_rdy", K_RS1RDY, 0, 1);
        push_exp("rst2_dsp_rename", K_REN, 0, 1);
`ifdef RENAME_PERF_EN
        push_exp("rst2_stall", K_STALL, 0, 0);
`endif
        @(negedge CLK);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
